serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: walks WIDTH operand bits LSB first through an external registered full adder.
// Latency WIDTH+1 edges from accepted start to done; start is ignored while busy, so there is no backpressure.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co
);

  localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-2:0] sh_q, sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    sh_d     = sh_q;
    result_d = result_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          a_d     = op_a;
          b_d     = op_b;
          cin_d   = cin;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // fa_s at k reflects bit k-1, so nothing valid returns until k=1
        if (k_q != '0) begin
          sh_d = (WIDTH-1)'({fa_s, sh_q} >> 1);
        end
        k_d = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        result_d = {fa_s, sh_q};
        cout_d   = fa_co;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      sh_q     <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  // Adder inputs are decoded from state only, so reset silences them at once
  always_comb begin
    fa_a  = 1'b0;
    fa_b  = 1'b0;
    fa_ci = 1'b0;
    if (state_q == RUN) begin
      fa_a  = a_q[k_q];
      fa_b  = b_q[k_q];
      fa_ci = (k_q == '0) ? cin_q : fa_co;
    end
  end

  assign busy   = (state_q == RUN) || (state_q == DRAIN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;

endmodule
